// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: scan-code prefixes, frame length, the
// receiver FSM state type, game-control key codes and a parity helper.
package ps2_pkg;

    localparam logic [7:0]  PS2_EXT_PREFIX = 8'hE0;
    localparam logic [7:0]  PS2_BRK_PREFIX = 8'hF0;
    localparam int unsigned PS2_FRAME_BITS = 11;

    typedef enum logic [1:0] {
        IDLE,
        RX,
        CHECK
    } ps2_rx_state_t;

    // Set-2 scan codes used by the game-control decoders
    localparam logic [7:0] KEY_SPACE = 8'h29;
    localparam logic [7:0] KEY_ENTER = 8'h5A;
    localparam logic [7:0] KEY_W     = 8'h1D;
    localparam logic [7:0] KEY_A     = 8'h1C;
    localparam logic [7:0] KEY_S     = 8'h1B;
    localparam logic [7:0] KEY_D     = 8'h23;
    localparam logic [7:0] KEY_UP    = 8'h75;  // E0-prefixed
    localparam logic [7:0] KEY_DOWN  = 8'h72;  // E0-prefixed
    localparam logic [7:0] KEY_LEFT  = 8'h6B;  // E0-prefixed
    localparam logic [7:0] KEY_RIGHT = 8'h74;  // E0-prefixed

    // Data bits plus parity bit must hold an odd number of ones
    function automatic logic odd_parity_ok(input logic [8:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Synchronizes the asynchronous PS/2 clock and data lines into clk and
// flags falling edges of the synchronized PS/2 clock.
// Ports:
//   clk, rst  : system clock, async active-high reset
//   ps2_clk   : raw keyboard clock
//   ps2_data  : raw keyboard data
//   data_s    : synchronized data line
//   fall      : high for one clk cycle per PS/2 clock falling edge
module ps2_sync_edge
    import ps2_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic data_s,
    output logic fall
);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   clk_prev_q;

    // Reset to the idle-high bus level so leaving reset never looks like an edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
            clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
        end
    end

    assign data_s = data_sync_q[SYNC_STAGES-1];
    assign fall   = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: deserializes 11-bit frames, strips E0/F0 prefixes
// and presents one held key event per complete scan sequence.
// Build option: define PS2_PARITY_CHECK_EN to reject frames with bad odd
// parity; otherwise the parity bit is sampled but ignored.
// Ports:
//   clk, rst           : system clock, async active-high reset
//   ps2_clk, ps2_data  : raw keyboard lines (asynchronous)
//   keycode            : last decoded scan code, prefixes removed (held)
//   make               : 1 = press, 0 = release (held)
//   ext                : 1 = code was E0-prefixed (held)
//   key_valid          : one-cycle strobe when keycode/make/ext update
//   frame_err          : one-cycle strobe on bad start/stop/parity or timeout
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned TO_W           = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic       make,
    output logic       ext,
    output logic       key_valid,
    output logic       frame_err
);

    localparam int unsigned BITCNT_W = 4;
    localparam logic [BITCNT_W-1:0] STOP_IDX = BITCNT_W'(PS2_FRAME_BITS - 1);
    localparam logic [TO_W-1:0]     TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    logic data_s;
    logic fall;

    ps2_rx_state_t                state_q;
    logic [BITCNT_W-1:0]          bitcnt_q;
    logic [PS2_FRAME_BITS-1:0]    shift_q;
    logic [TO_W-1:0]              to_q;
    logic                         ext_pend_q;
    logic                         brk_pend_q;
    logic [7:0]                   keycode_q;
    logic                         make_q;
    logic                         ext_q;
    logic                         key_valid_q;
    logic                         frame_err_q;

    logic [PS2_FRAME_BITS-1:0]    shift_d;
    logic [7:0]                   byte_c;
    logic                         parity_ok_c;
    logic                         frame_ok_c;

    ps2_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .data_s   (data_s),
        .fall     (fall)
    );

    // LSB-first: new bit enters at the top, so after 11 bits
    // [0]=start, [8:1]=data, [9]=parity, [10]=stop
    assign shift_d = {data_s, shift_q[PS2_FRAME_BITS-1:1]};
    assign byte_c  = shift_q[8:1];

`ifdef PS2_PARITY_CHECK_EN
    assign parity_ok_c = odd_parity_ok(shift_q[9:1]);
`else
    assign parity_ok_c = 1'b1;
`endif

    assign frame_ok_c = ~shift_q[0] & shift_q[10] & parity_ok_c;

    // Receiver FSM, prefix tracking and registered event outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            to_q        <= '0;
            ext_pend_q  <= 1'b0;
            brk_pend_q  <= 1'b0;
            keycode_q   <= 8'h00;
            make_q      <= 1'b0;
            ext_q       <= 1'b0;
            key_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    to_q <= '0;
                    // Only a low start bit opens a frame
                    if (fall && !data_s) begin
                        shift_q  <= shift_d;
                        bitcnt_q <= BITCNT_W'(1);
                        state_q  <= RX;
                    end
                end
                RX: begin
                    if (fall) begin
                        shift_q <= shift_d;
                        to_q    <= '0;
                        if (bitcnt_q == STOP_IDX) begin
                            state_q <= CHECK;
                        end else begin
                            bitcnt_q <= bitcnt_q + BITCNT_W'(1);
                        end
                    end else if (to_q == TO_LAST) begin
                        // Keyboard stalled mid-frame: abort and drop any prefix
                        state_q     <= IDLE;
                        to_q        <= '0;
                        frame_err_q <= 1'b1;
                        ext_pend_q  <= 1'b0;
                        brk_pend_q  <= 1'b0;
                    end else begin
                        to_q <= to_q + TO_W'(1);
                    end
                end
                CHECK: begin
                    state_q <= IDLE;
                    to_q    <= '0;
                    if (!frame_ok_c) begin
                        frame_err_q <= 1'b1;
                        ext_pend_q  <= 1'b0;
                        brk_pend_q  <= 1'b0;
                    end else if (byte_c == PS2_EXT_PREFIX) begin
                        ext_pend_q <= 1'b1;
                    end else if (byte_c == PS2_BRK_PREFIX) begin
                        brk_pend_q <= 1'b1;
                    end else begin
                        keycode_q   <= byte_c;
                        make_q      <= ~brk_pend_q;
                        ext_q       <= ext_pend_q;
                        key_valid_q <= 1'b1;
                        ext_pend_q  <= 1'b0;
                        brk_pend_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign keycode   = keycode_q;
    assign make      = make_q;
    assign ext       = ext_q;
    assign key_valid = key_valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Self-checking bench for ps2_keyboard_rx: table of frames with expected
// strobe timing and held outputs, plus timeout and mid-frame reset sequences.
module tb_ps2_keyboard_rx;

    localparam int HALF = 20;   // PS/2 half-period in clk cycles

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] keycode;
    logic       make;
    logic       ext;
    logic       key_valid;
    logic       frame_err;

    int checks  = 0;
    int errors  = 0;
    int overlap = 0;

    always #5 clk = ~clk;

    ps2_keyboard_rx #(
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (200),
        .TO_W           (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .keycode   (keycode),
        .make      (make),
        .ext       (ext),
        .key_valid (key_valid),
        .frame_err (frame_err)
    );

    always @(negedge clk) if (key_valid && frame_err) overlap++;

    typedef struct {
        logic [7:0] d;
        logic       flip;
        logic       stop;
        logic       exp_kv;
        logic       exp_fe;
        logic [7:0] exp_kc;
        logic       exp_mk;
        logic       exp_ex;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic flip, input logic stop);
        return {stop, (~^d) ^ flip, d, 1'b0};
    endfunction

    task automatic ps2_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    // Sends a frame; traces strobes for 6 clk negedges after the stop-bit fall.
    // Expected strobe slot: 2 sync stages + CHECK + output register = bit 3.
    task automatic send_frame(input logic [7:0] d, input logic flip, input logic stop,
                              output logic [5:0] kv_tr, output logic [5:0] fe_tr);
        logic [10:0] f;
        f = frame_bits(d, flip, stop);
        for (int i = 0; i < 10; i++) ps2_bit(f[i]);
        @(negedge clk);
        ps2_data = f[10];
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            kv_tr[i] = key_valid;
            fe_tr[i] = frame_err;
        end
        repeat (HALF - 6) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] kv_tr;
        logic [5:0] fe_tr;
        logic [7:0] hold_kc;
        int         first_fe;
        int         fe_cnt;
        int         kv_cnt;
        int         strobes;

`ifdef PS2_PARITY_CHECK_EN
        hold_kc = 8'h1D;
`else
        hold_kc = 8'h29;
`endif
        vecs[0]  = '{8'h29, 1'b0, 1'b1, 1'b1, 1'b0, 8'h29, 1'b1, 1'b0};
        vecs[1]  = '{8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h29, 1'b1, 1'b0};
        vecs[2]  = '{8'h29, 1'b0, 1'b1, 1'b1, 1'b0, 8'h29, 1'b0, 1'b0};
        vecs[3]  = '{8'hE0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h29, 1'b0, 1'b0};
        vecs[4]  = '{8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h29, 1'b0, 1'b0};
        vecs[5]  = '{8'h75, 1'b0, 1'b1, 1'b1, 1'b0, 8'h75, 1'b0, 1'b1};
        vecs[6]  = '{8'h1D, 1'b0, 1'b1, 1'b1, 1'b0, 8'h1D, 1'b1, 1'b0};
`ifdef PS2_PARITY_CHECK_EN
        vecs[7]  = '{8'h29, 1'b1, 1'b1, 1'b0, 1'b1, 8'h1D, 1'b1, 1'b0};
`else
        vecs[7]  = '{8'h29, 1'b1, 1'b1, 1'b1, 1'b0, 8'h29, 1'b1, 1'b0};
`endif
        vecs[8]  = '{8'hE0, 1'b0, 1'b1, 1'b0, 1'b0, hold_kc, 1'b1, 1'b0};
        vecs[9]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b1, hold_kc, 1'b1, 1'b0};
        vecs[10] = '{8'h75, 1'b0, 1'b1, 1'b1, 1'b0, 8'h75, 1'b1, 1'b0};
        vecs[11] = '{8'hE0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h75, 1'b1, 1'b0};
        vecs[12] = '{8'hE0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h75, 1'b1, 1'b0};
        vecs[13] = '{8'h6B, 1'b0, 1'b1, 1'b1, 1'b0, 8'h6B, 1'b1, 1'b1};
        vecs[14] = '{8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h6B, 1'b1, 1'b1};
        vecs[15] = '{8'hE0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h6B, 1'b1, 1'b1};
        vecs[16] = '{8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b1};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", {keycode, make, ext, key_valid, frame_err}, 12'h000);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Table-driven frames
        for (int i = 0; i < 17; i++) begin
            send_frame(vecs[i].d, vecs[i].flip, vecs[i].stop, kv_tr, fe_tr);
            check($sformatf("vec%0d_key_valid_trace", i), kv_tr, vecs[i].exp_kv ? 6'b001000 : 6'b000000);
            check($sformatf("vec%0d_frame_err_trace", i), fe_tr, vecs[i].exp_fe ? 6'b001000 : 6'b000000);
            check($sformatf("vec%0d_outputs", i), {keycode, make, ext},
                  {vecs[i].exp_kc, vecs[i].exp_mk, vecs[i].exp_ex});
        end

        // Timeout: start bit + 4 data bits of 0x29, then the line goes quiet
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b0);
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        first_fe = 0;
        fe_cnt   = 0;
        kv_cnt   = 0;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (n == HALF) ps2_clk = 1'b1;
            if (frame_err) begin
                fe_cnt++;
                if (first_fe == 0) first_fe = n;
            end
            if (key_valid) kv_cnt++;
        end
        // 200 idle cycles plus sync and register latency after the last fall
        check("timeout_frame_err_window", (first_fe >= 200 && first_fe <= 206) ? 1 : 0, 1);
        check("timeout_frame_err_count", fe_cnt, 1);
        check("timeout_no_key_valid", kv_cnt, 0);
        check("timeout_outputs_held", {keycode, make, ext}, {8'h5A, 1'b0, 1'b1});
        send_frame(8'h29, 1'b0, 1'b1, kv_tr, fe_tr);
        check("post_timeout_key_valid_trace", kv_tr, 6'b001000);
        check("post_timeout_outputs", {keycode, make, ext}, {8'h29, 1'b1, 1'b0});

        // Reset in the middle of a frame
        send_frame(8'h75, 1'b0, 1'b1, kv_tr, fe_tr);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midframe_reset_outputs", {keycode, make, ext, key_valid, frame_err}, 12'h000);
        strobes = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (key_valid || frame_err) strobes++;
        end
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (key_valid || frame_err) strobes++;
        end
        check("midframe_reset_no_strobe", strobes, 0);
        send_frame(8'h29, 1'b0, 1'b1, kv_tr, fe_tr);
        check("post_reset_key_valid_trace", kv_tr, 6'b001000);
        check("post_reset_frame_err_trace", fe_tr, 6'b000000);
        check("post_reset_outputs", {keycode, make, ext}, {8'h29, 1'b1, 1'b0});

        check("strobe_overlap", overlap, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
